// File: rtl/filt_ppd_pkg.sv
// Shared helpers for the polyphase decimator: sizing functions and the
// mapping from (phase, tap) to a prototype-filter coefficient index.
package filt_ppd_pkg;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(value)) r++;
    end
    return r;
  endfunction

  // Ceiling division, used for the number of taps held by each phase bank.
  function automatic int div_ceil(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Tap t of bank p reads h[t*M+p]; -1 marks a tap past the end of the
  // prototype filter, which the bank treats as a zero coefficient.
  function automatic int coeff_idx(input int p, input int t, input int m, input int l);
    int idx;
    idx = t * m + p;
    return (idx < l) ? idx : -1;
  endfunction

endpackage

// File: rtl/filt_ppd_if.sv
// Sample-in / decimated-sample-out bundle of the polyphase decimator.
interface filt_ppd_if #(
  parameter int gp_idata_width = 8,
  parameter int gp_odata_width = 30
) ();
  logic                             i_ena;
  logic signed [gp_idata_width-1:0] i_data;
  logic signed [gp_odata_width-1:0] o_data;
  logic                             o_valid;

  // Sample source / result consumer side.
  modport master (output i_ena, output i_data, input o_data, input o_valid);
  // Filter side.
  modport slave  (input i_ena, input i_data, output o_data, output o_valid);
endinterface

// File: rtl/ppd_phase_bank.sv
// One polyphase branch: a K-deep delay line and its K-tap dot product.
// The result is formed on the post-shift contents, so it already includes
// the sample being written this cycle.
module ppd_phase_bank
  import filt_ppd_pkg::*;
#(
  parameter int iw = 8,
  parameter int cw = 16,
  parameter int ow = 30,
  parameter int m  = 8,
  parameter int l  = 53,
  parameter int k  = 7,
  parameter int p  = 0,
  parameter logic [l*cw-1:0] coeffs = {l{cw'(1)}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic signed [iw-1:0] sample,
  output logic signed [ow-1:0] result
);

  logic signed [iw-1:0]    taps      [k];
  logic signed [iw-1:0]    next_taps [k];
  logic signed [cw-1:0]    coeff     [k];
  logic signed [iw+cw-1:0] prod      [k];

  for (genvar gi = 0; gi < k; gi++) begin : g_tap
    localparam int idx = coeff_idx(p, gi, m, l);

    if (gi == 0) begin : g_head
      assign next_taps[gi] = sample;
    end else begin : g_body
      assign next_taps[gi] = taps[gi-1];
    end

    if (idx >= 0) begin : g_coef
      assign coeff[gi] = coeffs[idx*cw +: cw];
    end else begin : g_zero
      assign coeff[gi] = '0;
    end

    // Both operands widened to the full product width before multiplying.
    assign prod[gi] = $signed({{cw{next_taps[gi][iw-1]}}, next_taps[gi]}) *
                      $signed({{iw{coeff[gi][cw-1]}}, coeff[gi]});

    // Delay-line stage: shifts one place whenever this bank is written.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        taps[gi] <= '0;
      end else if (wr_en) begin
        taps[gi] <= next_taps[gi];
      end
    end
  end

  // Sign-extended sum of the tap products.
  always_comb begin
    result = '0;
    for (int t = 0; t < k; t++) begin
      result = result + {{(ow-iw-cw){prod[t][iw+cw-1]}}, prod[t]};
    end
  end

endmodule

// File: rtl/filt_ppd.sv
// Polyphase decimation FIR: a commutator steers each accepted sample into
// bank M-1-j, the active bank's result is accumulated over the frame, and
// one output with a single-cycle valid pulse is produced per M samples.
module filt_ppd
  import filt_ppd_pkg::*;
#(
  parameter int gp_idata_width       = 8,
  parameter int gp_decimation_factor = 8,
  parameter int gp_coeff_length      = 53,
  parameter int gp_coeff_width       = 16,
  parameter logic [gp_coeff_length*gp_coeff_width-1:0] gp_coeffs =
    {gp_coeff_length{gp_coeff_width'(1)}},
  parameter int gp_comm_phase        = 0,
  parameter int gp_odata_width       = gp_idata_width + gp_coeff_width + clog2(gp_coeff_length)
) (
  input logic       i_clk,
  input logic       i_rst,
  filt_ppd_if.slave bus
);

  localparam int m  = gp_decimation_factor;
  localparam int k  = div_ceil(gp_coeff_length, m);
  localparam int jw = (clog2(m) > 0) ? clog2(m) : 1;
  localparam logic [jw-1:0] j_last  = jw'(m - 1);
  localparam logic [jw-1:0] j_reset = jw'(gp_comm_phase);

  logic [jw-1:0]                   j;
  logic [m-1:0]                    wr_en;
  logic signed [gp_odata_width-1:0] results [m];
  logic [jw-1:0]                   sel;
  logic                            first;
  logic                            last;
  logic signed [gp_odata_width-1:0] base;
  logic signed [gp_odata_width-1:0] sum;
  logic signed [gp_odata_width-1:0] acc;
  logic signed [gp_odata_width-1:0] data_out;
  logic                            valid_out;

  for (genvar gi = 0; gi < m; gi++) begin : g_bank
    assign wr_en[gi] = bus.i_ena && (j == jw'(m - 1 - gi));

    ppd_phase_bank #(
      .iw     (gp_idata_width),
      .cw     (gp_coeff_width),
      .ow     (gp_odata_width),
      .m      (m),
      .l      (gp_coeff_length),
      .k      (k),
      .p      (gi),
      .coeffs (gp_coeffs)
    ) u_bank (
      .clk    (i_clk),
      .rst    (i_rst),
      .wr_en  (wr_en[gi]),
      .sample (bus.i_data),
      .result (results[gi])
    );
  end

  // Select the active bank's result and fold it into the running frame sum;
  // the first sample of a frame starts from zero instead of the stale acc.
  always_comb begin
    sel   = j_last - j;
    first = (j == '0);
    last  = (j == j_last);
    base  = first ? '0 : acc;
    sum   = base + results[sel];
  end

  // Commutator, accumulator and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      j         <= j_reset;
      acc       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (bus.i_ena) begin
        j <= last ? '0 : j + 1'b1;
        if (last) begin
          data_out  <= sum;
          valid_out <= 1'b1;
        end else begin
          acc <= sum;
        end
      end
    end
  end

  assign bus.o_data  = data_out;
  assign bus.o_valid = valid_out;

endmodule

// File: tb/tb_filt_ppd.sv
// Directed bench for filt_ppd: two instances (commutator phase 0 and 5)
// share clock, reset and stimulus; outputs are collected per frame and
// compared against hand-computed sequences.
module tb_filt_ppd;

  localparam int iw = 8;
  localparam int ow = 30;

  logic                 clk;
  logic                 rst;
  logic                 ena;
  logic signed [iw-1:0] din;
  int                   cyc;
  int                   n_acc;
  int                   checks;
  int                   failures;
  logic                 hold_chk;
  longint               last_out;

  longint q0[$];
  longint q5[$];
  int     c0[$];
  int     n0[$];
  int     n5[$];

  filt_ppd_if #(.gp_idata_width(iw), .gp_odata_width(ow)) bus0 ();
  filt_ppd_if #(.gp_idata_width(iw), .gp_odata_width(ow)) bus5 ();

  assign bus0.i_ena  = ena;
  assign bus0.i_data = din;
  assign bus5.i_ena  = ena;
  assign bus5.i_data = din;

  filt_ppd #(.gp_comm_phase(0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  filt_ppd #(.gp_comm_phase(5)) dut5 (.i_clk(clk), .i_rst(rst), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Assert reset, confirm outputs clear asynchronously, release after 2 edges.
  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b0;
    din = '0;
    #1;
    check("rst_data0", bus0.o_data, 0);
    check("rst_valid0", bus0.o_valid, 0);
    check("rst_data5", bus5.o_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete(); q5.delete(); c0.delete(); n0.delete(); n5.delete();
    n_acc    = 0;
    last_out = 0;
  endtask

  // Present one sample for one cycle, then idle for gap cycles.
  task automatic push(input logic signed [iw-1:0] x, input int gap);
    ena = 1'b1;
    din = x;
    @(posedge clk);
    #1;
    ena = 1'b0;
    n_acc++;
    if (bus0.o_valid) begin
      q0.push_back(bus0.o_data);
      c0.push_back(cyc);
      n0.push_back(n_acc);
      last_out = bus0.o_data;
      $display("out0 sample=%0d cyc=%0d data=%0d", n_acc, cyc, bus0.o_data);
    end
    if (bus5.o_valid) begin
      q5.push_back(bus5.o_data);
      n5.push_back(n_acc);
      $display("out5 sample=%0d cyc=%0d data=%0d", n_acc, cyc, bus5.o_data);
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      if (hold_chk) begin
        check("gap_hold", bus0.o_data, last_out);
        check("gap_valid", bus0.o_valid, 0);
      end
    end
  endtask

  task automatic check_seq(input string tag, input longint exp[$]);
    check({tag, "_count"}, q0.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < q0.size()) check(tag, q0[i], exp[i]);
    end
  endtask

  task automatic check_period(input string tag, input int period);
    for (int i = 1; i < c0.size(); i++) check(tag, c0[i] - c0[i-1], period);
  endtask

  initial begin
    longint exp_imp[$];
    longint exp_dc[$];
    longint exp_ph5[$];
    longint exp_fs[$];

    exp_imp = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    exp_dc  = '{8, 16, 24, 32, 40, 48, 53, 53};
    exp_ph5 = '{3, 11, 19, 27, 35, 43, 51, 53};
    exp_fs  = '{-1024, -2048, -3072, -4096, -5120, -6144, -6784, -6784};

    cyc = 0; checks = 0; failures = 0; hold_chk = 1'b0; last_out = 0;
    rst = 1'b0; ena = 1'b0; din = '0;
    #2;
    do_reset();

    // Impulse response: taps 7,15,...,47 then zero.
    push(1, 0);
    for (int i = 0; i < 71; i++) push(0, 0);
    check_seq("impulse", exp_imp);
    check_period("impulse_period", 8);
    if (n0.size() > 0) check("impulse_first", n0[0], 8);

    // DC step on both instances; phase-5 instance emits after 3 samples.
    do_reset();
    for (int i = 0; i < 64; i++) push(1, 0);
    check_seq("dc", exp_dc);
    check("ph5_count", q5.size(), exp_ph5.size());
    for (int i = 0; i < exp_ph5.size(); i++) begin
      if (i < q5.size()) check("ph5", q5[i], exp_ph5[i]);
    end
    if (n5.size() > 0) check("ph5_first", n5[0], 3);
    check("dc_held", bus0.o_data, 53);

    // Full-scale negative DC.
    do_reset();
    for (int i = 0; i < 64; i++) push(-128, 0);
    check_seq("fullscale", exp_fs);
    check("fullscale_held", bus0.o_data, -6784);

    // 50% enable duty: same values, twice the period, output held between.
    do_reset();
    hold_chk = 1'b1;
    for (int i = 0; i < 64; i++) push(1, 1);
    hold_chk = 1'b0;
    check_seq("gapped", exp_dc);
    check_period("gapped_period", 16);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 3; i++) push(100, 0);
    #3;
    do_reset();
    for (int i = 0; i < 8; i++) push(1, 0);
    check("midrst_count", q0.size(), 1);
    if (q0.size() > 0) check("midrst_value", q0[0], 8);
    if (n0.size() > 0) check("midrst_first", n0[0], 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
